// File: rtl/divide_unit.sv
// divide_unit: multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU
// instructions. The result is delivered through a register-file write port
// that is separate from the main pipeline's port.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   start          request a divide; accepted only while busy is low
//   funct          00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend       rs1 value
//   divisor        rs2 value
//   destination    rd
//   cancel         pipeline flush; abandons any operation at the next edge
//   busy           high from acceptance until the result cycle ends
//   write_address  rd during the result cycle, otherwise 0 (0 means no write)
//   write_value    result; meaningful only when write_address != 0
//   fsm_state      current controller state (IDLE=0, DIVIDE=1, DONE=2)
//
// Handshake: start is a request qualified by busy. A request is taken at the
// rising edge where start=1, cancel=0 and busy=0. Any other start is dropped.
// The result is presented for exactly one cycle, and write_address is the
// valid qualifier for write_value.

module divide_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            funct,
    input  logic [XLEN-1:0]       dividend,
    input  logic [XLEN-1:0]       divisor,
    input  logic [ADDR_WIDTH-1:0] destination,
    input  logic                  cancel,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [XLEN-1:0]       write_value,
    output logic [1:0]            fsm_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic                  rem_sel_q;   // 1: remainder wanted, 0: quotient
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [XLEN-1:0]       quo_q;       // dividend magnitude shifting out, quotient bits shifting in
    logic [XLEN-1:0]       rem_q;       // partial remainder
    logic [XLEN-1:0]       div_q;       // divisor magnitude
    logic                  q_neg_q;
    logic                  r_neg_q;
    logic [XLEN-1:0]       result_q;

    // Operand preparation at acceptance.
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_result;

    always_comb begin
        is_signed = ~funct[0];
        a_neg     = is_signed & dividend[XLEN-1];
        b_neg     = is_signed & divisor[XLEN-1];
        a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
        div_zero  = (divisor == '0);
        overflow  = is_signed && (dividend == MIN_INT) && (divisor == '1);
        if (div_zero)
            special_result = funct[1] ? dividend : '1;
        else
            special_result = funct[1] ? '0 : dividend;
    end

    // One restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            take;
    logic [XLEN-1:0] next_rem;
    logic [XLEN-1:0] next_quo;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, div_q};
        take     = ~diff[XLEN];
        next_rem = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        next_quo = {quo_q[XLEN-2:0], take};
        q_fix    = q_neg_q ? (~next_quo + 1'b1) : next_quo;
        r_fix    = r_neg_q ? (~next_rem + 1'b1) : next_rem;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            rem_sel_q <= 1'b0;
            rd_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else if (cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_sel_q <= funct[1];
                        rd_q      <= destination;
                        if (div_zero || overflow) begin
                            result_q <= special_result;
                            state    <= DONE;
                        end else begin
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            div_q   <= b_mag;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            count   <= CW'(XLEN - 1);
                            state   <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    quo_q <= next_quo;
                    rem_q <= next_rem;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        result_q <= rem_sel_q ? r_fix : q_fix;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy          = (state != IDLE);
    // cancel during the result cycle must kill the write in that same cycle.
    assign write_address = (state == DONE && !cancel) ? rd_q : '0;
    assign write_value   = result_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_divide_unit.sv
module tb_divide_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  destination;
    logic        cancel;
    logic        busy;
    logic [4:0]  write_address;
    logic [31:0] write_value;
    logic [1:0]  fsm_state;

    divide_unit #(.XLEN(32), .ADDR_WIDTH(5)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .funct(funct),
        .dividend(dividend),
        .divisor(divisor),
        .destination(destination),
        .cancel(cancel),
        .busy(busy),
        .write_address(write_address),
        .write_value(write_value),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] value;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RISC-V division semantics in plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
            sa = a;
            sb = b;
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Monitor: every nonzero write must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && write_address != 5'd0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d value 0x%08h at cycle %0d, none expected",
                         write_address, write_value, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(write_address), 32'(e.addr));
                check("write_value", write_value, e.value);
                check("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Counts result-in-flight cycles seen at negedges after acceptance.
    task automatic count_busy(output int n);
        n = 0;
        forever begin
            @(negedge clock);
            if (!busy || n >= 100) break;
            n++;
        end
    endtask

    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_v);
        int lat;
        int n;
        exp_t e;
        wait_idle();
        @(negedge clock);
        start = 1'b1; funct = f; dividend = a; divisor = b; destination = rd;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = is_special(f, a, b) ? 1 : 33;
        if (rd != 5'd0) begin
            e.addr = rd; e.value = exp_v; e.cyc = cyc + lat - 1;
            exp_q.push_back(e);
        end
        count_busy(n);
        check("busy_cycles", 32'(n), 32'(lat));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        exp_t e;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;

        reset = 1'b1; start = 1'b0; cancel = 1'b0; funct = 2'd0;
        dividend = '0; divisor = '0; destination = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_waddr", 32'(write_address), 32'd0);
        check("reset_wvalue", write_value, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed arithmetic cases.
        run_op(2'b01, 32'd100, 32'd7, 5'd5, 32'd14);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'h0000_0001);
        run_op(2'b01, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd5, 32'd0, 5'd8, 32'd5);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'd1, 5'd9, 32'h8000_0000);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'd1);
        run_op(2'b00, 32'd100, 32'd7, 5'd0, 32'd14);

        // Second start while busy is ignored.
        wait_idle();
        @(negedge clock);
        start = 1'b1; funct = 2'b01; dividend = 32'd1000; divisor = 32'd10; destination = 5'd12;
        @(posedge clock);
        #1;
        start = 1'b0;
        e.addr = 5'd12; e.value = 32'd100; e.cyc = cyc + 32;
        exp_q.push_back(e);
        n = 0;
        forever begin
            @(negedge clock);
            start = 1'b0;
            if (!busy || n >= 100) break;
            n++;
            if (n == 4) begin
                start = 1'b1; funct = 2'b01; dividend = 32'd9; divisor = 32'd3; destination = 5'd13;
            end
        end
        start = 1'b0;
        check("busy_ignore_start", 32'(n), 32'd33);

        // Cancel during DIVIDE: no write, idle on the next cycle.
        @(negedge clock);
        start = 1'b1; funct = 2'b01; dividend = 32'd77; divisor = 32'd3; destination = 5'd14;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clock);
        cancel = 1'b1;
        @(posedge clock);
        #1;
        cancel = 1'b0;
        @(negedge clock);
        check("cancel_busy", 32'(busy), 32'd0);
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd15, 32'hFFFF_FFF2);

        // Cancel in the DONE cycle suppresses the write.
        wait_idle();
        @(negedge clock);
        start = 1'b1; funct = 2'b01; dividend = 32'd5; divisor = 32'd0; destination = 5'd4;
        @(posedge clock);
        #1;
        start = 1'b0;
        cancel = 1'b1;
        @(negedge clock);
        check("cancel_done_waddr", 32'(write_address), 32'd0);
        check("cancel_done_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        cancel = 1'b0;
        @(negedge clock);
        check("cancel_done_idle", 32'(busy), 32'd0);

        // Cancel together with start in IDLE: nothing accepted.
        @(negedge clock);
        start = 1'b1; cancel = 1'b1; funct = 2'b01; dividend = 32'd50; divisor = 32'd5; destination = 5'd16;
        @(posedge clock);
        #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clock);
        check("cancel_start_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation.
        @(negedge clock);
        start = 1'b1; funct = 2'b01; dividend = 32'd900; divisor = 32'd7; destination = 5'd6;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (19) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_waddr", 32'(write_address), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        run_op(2'b01, 32'd900, 32'd7, 5'd6, 32'd128);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            f  = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'd1;
                3: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
                4: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(f, a, b, rd, ref_div(f, a, b));
        end

        repeat (5) @(negedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
